// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester
// and a data (load/store) requester. At most one memory transaction is in
// flight. Data normally wins arbitration. After STARVE_LIMIT consecutive data
// grants while fetch is waiting, the next grant goes to fetch.
//
// Handshakes:
//   Requester side: req is held high with its command stable until that
//   requester's ready pulses for one cycle. rdata is valid in that cycle. A
//   request still high in the ready cycle is arbitrated again at the same edge.
//   Memory side: mem_req is high with mem_* stable until an edge where
//   mem_req && mem_gnt. mem_rvalid acknowledges that command one or more
//   cycles later. mem_gnt outside REQ and mem_rvalid outside RESP are ignored.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   if_req/if_addr           fetch request; if_ready/if_rdata its completion
//   d_req/d_we/d_addr/...    data request; d_ready/d_rdata its completion
//   mem_req/mem_we/...       registered command toward memory
//   mem_gnt/mem_rvalid/...   memory accept / response
//   busy                     high whenever the FSM is not IDLE
//   fsm_state                debug view of the FSM state (0 IDLE, 1 REQ, 2 RESP)
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic [1:0]  fsm_state
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        owner_data;   // 0 = fetch owns the transaction, 1 = data
  logic [3:0]  starve_cnt;
  logic        grant;
  logic        fetch_win;

  // Fetch wins when it is the only requester, or when data has already been
  // granted LIMIT times in a row while fetch was waiting.
  assign fetch_win = if_req && (!d_req || (starve_cnt == LIMIT));
  assign grant     = (state == IDLE) && (if_req || d_req);

  assign mem_req   = (state == REQ);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (if_req || d_req) state_nxt = REQ;
      REQ:     if (mem_gnt)         state_nxt = RESP;
      RESP:    if (mem_rvalid)      state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner_data <= 1'b0;
      starve_cnt <= 4'd0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_be     <= 4'h0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      if_rdata   <= 32'h0;
      d_rdata    <= 32'h0;
    end else begin
      state    <= state_nxt;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;

      if (grant) begin
        owner_data <= !fetch_win;
        if (fetch_win) begin
          // Fetch is always a full-word read.
          mem_we     <= 1'b0;
          mem_addr   <= if_addr;
          mem_wdata  <= 32'h0;
          mem_be     <= 4'hF;
          starve_cnt <= 4'd0;
        end else begin
          mem_we    <= d_we;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
          mem_be    <= d_be;
          // Count only the data grants that made a waiting fetch wait longer.
          if (if_req) begin
            if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
          end else begin
            starve_cnt <= 4'd0;
          end
        end
      end

      if ((state == RESP) && mem_rvalid) begin
        if (owner_data) begin
          d_ready <= 1'b1;
          // Stores only acknowledge; the last load value stays visible.
          if (!mem_we) d_rdata <= mem_rdata;
        end else begin
          if_ready <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
